// File: rtl/game_pkg.sv
// Shared game-level types and constants for the scheduler, obstacle columns and renderer.
package game_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    CRASH = 2'd2,
    OVER  = 2'd3
  } game_state_t;

  localparam int SCREEN_W     = 640;
  localparam int PLAYER_COL_X = 210;
  localparam int SAFE_Y_RESET = 240;

  // Galois feedback mask for taps 16,14,13,11 (right-shifting form)
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr16_next(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ LFSR_TAPS) : (v >> 1);
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR; advances once per clock while en is high.
module lfsr16
  import game_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic [15:0] q
);

  logic [15:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (en) q_d = lfsr16_next(q_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_q <= SEED;
    else        q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/obstacle_scheduler.sv
// Game FSM and column-slot scheduler: spawn timing, random safebox placement,
// pass/crash feedback into score and gravity inversion.
module obstacle_scheduler
  import game_pkg::*;
#(
  parameter int          NUM_SLOTS    = 4,
  parameter int          SPAWN_GAP    = 32,
  parameter int          COL_SPEED    = 5,
  parameter int          SAFE_MIN     = 120,
  parameter int          SAFE_MAX     = 360,
  parameter int          CRASH_FRAMES = 60,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic                    frame_clk,
  input  logic                    Reset,
  input  logic                    start,
  input  logic [NUM_SLOTS-1:0]    slot_collide,
  input  logic [NUM_SLOTS-1:0]    slot_passed,
  output logic [NUM_SLOTS-1:0]    slot_spawn,
  output logic [NUM_SLOTS-1:0]    slot_active,
  output logic [NUM_SLOTS*10-1:0] slot_safe_y,
  output logic [NUM_SLOTS-1:0]    slot_flip,
  output logic [10:0]             col_speed,
  output logic [1:0]              game_state,
  output logic [15:0]             score,
  output logic                    gravity_inv
);

  localparam int GW = $clog2(SPAWN_GAP + 1);
  localparam int CW = $clog2(CRASH_FRAMES + 1);
  localparam int KW = $clog2(NUM_SLOTS + 1);
  localparam int SW = NUM_SLOTS * 10;

  game_state_t          state_q, state_d;
  logic [GW-1:0]        gap_q, gap_d;
  logic [CW-1:0]        crash_q, crash_d;
  logic [NUM_SLOTS-1:0] active_q, active_d;
  logic [NUM_SLOTS-1:0] spawn_q, spawn_d;
  logic [NUM_SLOTS-1:0] flip_q, flip_d;
  logic [NUM_SLOTS-1:0] pass_hist_q, pass_hist_d;
  logic [SW-1:0]        safe_y_q, safe_y_d;
  logic [10:0]          speed_q, speed_d;
  logic [15:0]          score_q, score_d;
  logic                 ginv_q, ginv_d;

  logic [15:0]          lfsr_q;
  logic                 unused_lfsr;
  logic [NUM_SLOTS-1:0] pass_edge;
  logic [KW-1:0]        pass_cnt;
  logic                 flip_par;
  logic [16:0]          score_sum;
  logic [10:0]          safe_raw;
  logic [9:0]           new_safe_y;
  logic                 crash_hit;
  logic                 spawn_taken;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (frame_clk),
    .rst_n (Reset),
    .en    (1'b1),
    .q     (lfsr_q)
  );

  assign unused_lfsr = ^lfsr_q[15:9];

  generate
    for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_edge
      assign pass_edge[gi] = slot_passed[gi] & active_q[gi] & ~pass_hist_q[gi];
    end
  endgenerate

  always_comb begin
    pass_cnt = '0;
    for (int i = 0; i < NUM_SLOTS; i++) pass_cnt = pass_cnt + KW'(pass_edge[i]);
    flip_par   = ^(pass_edge & flip_q);
    score_sum  = {1'b0, score_q} + 17'(pass_cnt);
    crash_hit  = |(slot_collide & active_q);
    safe_raw   = 11'(SAFE_MIN) + 11'(lfsr_q[7:0]);
    new_safe_y = (safe_raw > 11'(SAFE_MAX)) ? 10'(SAFE_MAX) : safe_raw[9:0];
  end

  always_comb begin
    state_d     = state_q;
    gap_d       = gap_q;
    crash_d     = crash_q;
    active_d    = active_q;
    spawn_d     = '0;
    flip_d      = flip_q;
    safe_y_d    = safe_y_q;
    speed_d     = speed_q;
    score_d     = score_q;
    ginv_d      = ginv_q;
    spawn_taken = 1'b0;
    // History is masked by active so a freshly spawned slot starts clean.
    pass_hist_d = slot_passed & active_q;

    case (state_q)
      IDLE: begin
        speed_d = '0;
        if (start) begin
          state_d  = RUN;
          speed_d  = 11'(COL_SPEED);
          score_d  = '0;
          ginv_d   = 1'b0;
          active_d = '0;
          gap_d    = '0;
        end
      end
      RUN: begin
        if (crash_hit) begin
          // Collision pre-empts any pass or spawn seen in the same frame.
          state_d = CRASH;
          speed_d = '0;
          crash_d = '0;
        end else begin
          speed_d  = 11'(COL_SPEED);
          score_d  = score_sum[16] ? 16'hFFFF : score_sum[15:0];
          ginv_d   = ginv_q ^ flip_par;
          active_d = active_q & ~pass_edge;
          if (gap_q == '0) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
              if (!spawn_taken && !active_q[i]) begin
                spawn_taken          = 1'b1;
                spawn_d[i]           = 1'b1;
                active_d[i]          = 1'b1;
                flip_d[i]            = lfsr_q[8];
                safe_y_d[10*i +: 10] = new_safe_y;
                pass_hist_d[i]       = 1'b0;
              end
            end
            if (spawn_taken) gap_d = GW'(SPAWN_GAP - 1);
          end else begin
            gap_d = gap_q - GW'(1);
          end
        end
      end
      CRASH: begin
        speed_d = '0;
        if (crash_q == CW'(CRASH_FRAMES - 1)) state_d = OVER;
        else                                  crash_d = crash_q + CW'(1);
      end
      OVER: begin
        speed_d = '0;
        if (start) begin
          state_d  = IDLE;
          active_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge frame_clk or negedge Reset) begin
    if (!Reset) begin
      state_q     <= IDLE;
      gap_q       <= '0;
      crash_q     <= '0;
      active_q    <= '0;
      spawn_q     <= '0;
      flip_q      <= '0;
      pass_hist_q <= '0;
      safe_y_q    <= {NUM_SLOTS{10'(SAFE_Y_RESET)}};
      speed_q     <= '0;
      score_q     <= '0;
      ginv_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      gap_q       <= gap_d;
      crash_q     <= crash_d;
      active_q    <= active_d;
      spawn_q     <= spawn_d;
      flip_q      <= flip_d;
      pass_hist_q <= pass_hist_d;
      safe_y_q    <= safe_y_d;
      speed_q     <= speed_d;
      score_q     <= score_d;
      ginv_q      <= ginv_d;
    end
  end

  assign slot_spawn  = spawn_q;
  assign slot_active = active_q;
  assign slot_safe_y = safe_y_q;
  assign slot_flip   = flip_q;
  assign col_speed   = speed_q;
  assign game_state  = state_q;
  assign score       = score_q;
  assign gravity_inv = ginv_q;

endmodule

// File: tb/tb_obstacle_scheduler.sv
// Directed self-checking bench for obstacle_scheduler.
module tb_obstacle_scheduler;

  logic        frame_clk = 1'b0;
  logic        Reset;
  logic        start;
  logic [3:0]  slot_collide;
  logic [3:0]  slot_passed;
  logic [3:0]  slot_spawn;
  logic [3:0]  slot_active;
  logic [39:0] slot_safe_y;
  logic [3:0]  slot_flip;
  logic [10:0] col_speed;
  logic [1:0]  game_state;
  logic [15:0] score;
  logic        gravity_inv;

  int n_cmp = 0;
  int n_err = 0;

  obstacle_scheduler dut (
    .frame_clk    (frame_clk),
    .Reset        (Reset),
    .start        (start),
    .slot_collide (slot_collide),
    .slot_passed  (slot_passed),
    .slot_spawn   (slot_spawn),
    .slot_active  (slot_active),
    .slot_safe_y  (slot_safe_y),
    .slot_flip    (slot_flip),
    .col_speed    (col_speed),
    .game_state   (game_state),
    .score        (score),
    .gravity_inv  (gravity_inv)
  );

  always #5 frame_clk = ~frame_clk;

  // Reference LFSR: m_used holds the value the design sampled at the last edge.
  logic [15:0] m_lfsr, m_used;

  function automatic logic [15:0] ref_next(input logic [15:0] v);
    logic [15:0] r;
    logic        b;
    b = v[0];
    r = {1'b0, v[15:1]};
    r[15] = b;
    r[13] = r[13] ^ b;
    r[12] = r[12] ^ b;
    r[10] = r[10] ^ b;
    return r;
  endfunction

  function automatic logic [9:0] exp_safe(input logic [15:0] u);
    int y;
    y = 120 + int'(u[7:0]);
    if (y > 360) y = 360;
    return 10'(y);
  endfunction

  always @(posedge frame_clk or negedge Reset) begin
    if (!Reset) begin
      m_lfsr <= 16'hACE1;
      m_used <= 16'hACE1;
    end else begin
      m_used <= m_lfsr;
      m_lfsr <= ref_next(m_lfsr);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge frame_clk);
    @(negedge frame_clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  spawn_seen;
    logic [3:0]  ef;
    logic [15:0] exp_score;
    logic        exp_ginv;
    logic [3:0]  jmask;
    logic [9:0]  sy;
    int          j;

    Reset = 1'b0; start = 1'b0; slot_collide = '0; slot_passed = '0;
    ef = '0;
    repeat (2) @(negedge frame_clk);
    chk("rst_state", game_state, 2'd0);
    chk("rst_safe_y", slot_safe_y, {4{10'd240}});
    chk("rst_speed", col_speed, 11'd0);
    Reset = 1'b1;
    tick();
    chk("idle_state", game_state, 2'd0);
    chk("idle_spawn", slot_spawn, 4'b0000);

    // Start: RUN next edge, first spawn the frame after, next one 32 frames later
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("run_state", game_state, 2'd1);
    chk("run_speed", col_speed, 11'd5);
    chk("run_nospawn_yet", slot_spawn, 4'b0000);
    tick();
    chk("spawn0", slot_spawn, 4'b0001);
    chk("active0", slot_active, 4'b0001);
    sy = slot_safe_y[9:0];
    chk("safe_y0", sy, exp_safe(m_used));
    chk("safe_y0_range", (sy >= 10'd120 && sy <= 10'd360), 1'b1);
    chk("flip0", slot_flip[0], m_used[8]);
    ef[0] = m_used[8];
    spawn_seen = '0;
    repeat (31) begin tick(); spawn_seen |= slot_spawn; end
    chk("gap_quiet", spawn_seen, 4'b0000);
    tick();
    chk("spawn1", slot_spawn, 4'b0010);
    chk("safe_y1", slot_safe_y[19:10], exp_safe(m_used));
    ef[1] = m_used[8];
    repeat (31) tick();
    tick();
    chk("spawn2", slot_spawn, 4'b0100);
    ef[2] = m_used[8];
    repeat (31) tick();
    tick();
    chk("spawn3", slot_spawn, 4'b1000);
    chk("safe_y3", slot_safe_y[39:30], exp_safe(m_used));
    ef[3] = m_used[8];
    chk("all_active", slot_active, 4'b1111);

    // All slots busy: spawn stalls until slot 2 is released
    spawn_seen = '0;
    repeat (40) begin tick(); spawn_seen |= slot_spawn; end
    chk("stall_nospawn", spawn_seen, 4'b0000);
    slot_passed = 4'b0100;
    tick();
    exp_score = 16'd1;
    exp_ginv  = ef[2];
    chk("rel2_active", slot_active, 4'b1011);
    chk("rel2_score", score, exp_score);
    chk("rel2_ginv", gravity_inv, exp_ginv);
    slot_passed = 4'b0000;
    tick();
    chk("respawn2", slot_spawn, 4'b0100);
    chk("respawn2_active", slot_active, 4'b1111);
    ef[2] = m_used[8];
    chk("respawn2_flip", slot_flip[2], ef[2]);

    // Level held 10 frames on a flip slot: one pass, one toggle
    j = 0;
    for (int k = 3; k >= 0; k--) if (ef[k]) j = k;
    jmask = 4'b0001 << j;
    slot_passed = jmask;
    spawn_seen = '0;
    repeat (10) begin tick(); spawn_seen |= slot_spawn; end
    exp_score = 16'd2;
    exp_ginv  = exp_ginv ^ ef[j];
    chk("hold_score", score, exp_score);
    chk("hold_ginv", gravity_inv, exp_ginv);
    chk("hold_active", slot_active, 4'b1111 & ~jmask);
    chk("hold_nospawn", spawn_seen, 4'b0000);
    slot_passed = 4'b0000;
    for (int k = 0; k < 40; k++) begin
      tick();
      if ((slot_spawn & jmask) != 4'b0000) ef[j] = m_used[8];
      if (slot_active == 4'b1111) break;
    end
    chk("refill_active", slot_active, 4'b1111);

    // Collision beats a simultaneous pass
    slot_collide = 4'b0010;
    slot_passed  = 4'b0001;
    tick();
    slot_collide = '0;
    slot_passed  = '0;
    chk("crash_state", game_state, 2'd2);
    chk("crash_score", score, exp_score);
    chk("crash_ginv", gravity_inv, exp_ginv);
    chk("crash_speed", col_speed, 11'd0);
    chk("crash_nospawn", slot_spawn, 4'b0000);
    repeat (9) tick();
    start = 1'b1;
    tick();
    tick();
    chk("crash_ignores_start", game_state, 2'd2);
    start = 1'b0;
    repeat (48) tick();
    chk("crash_hold59", game_state, 2'd2);
    tick();
    chk("over_state", game_state, 2'd3);
    chk("over_speed", col_speed, 11'd0);

    // start held: OVER -> IDLE -> RUN, one step per frame
    start = 1'b1;
    tick();
    chk("to_idle", game_state, 2'd0);
    chk("idle_score_held", score, exp_score);
    chk("idle_active_clr", slot_active, 4'b0000);
    tick();
    start = 1'b0;
    chk("rerun_state", game_state, 2'd1);
    chk("rerun_score", score, 16'd0);
    chk("rerun_ginv", gravity_inv, 1'b0);

    // Saturation: preload near max, two passes in one frame
    for (int k = 0; k < 40; k++) begin
      tick();
      if (slot_active == 4'b0011) break;
    end
    chk("sat_setup", slot_active, 4'b0011);
    force dut.score_q = 16'hFFFE;
    #1;
    release dut.score_q;
    slot_passed = 4'b0011;
    tick();
    slot_passed = 4'b0000;
    chk("sat_score", score, 16'hFFFF);
    chk("sat_active", slot_active, 4'b0000);

    // Asynchronous reset mid-RUN with a spawn pulse in flight
    for (int k = 0; k < 80; k++) begin
      if (slot_spawn == 4'b0010) break;
      tick();
    end
    chk("pre_rst_spawn", slot_spawn, 4'b0010);
    chk("pre_rst_active", slot_active, 4'b0011);
    #2;
    Reset = 1'b0;
    #1;
    chk("arst_state", game_state, 2'd0);
    chk("arst_spawn", slot_spawn, 4'b0000);
    chk("arst_active", slot_active, 4'b0000);
    chk("arst_flip", slot_flip, 4'b0000);
    chk("arst_safe_y", slot_safe_y, {4{10'd240}});
    chk("arst_speed", col_speed, 11'd0);
    chk("arst_score", score, 16'd0);
    chk("arst_ginv", gravity_inv, 1'b0);
    chk("arst_lfsr", dut.lfsr_q, 16'hACE1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
